misao_mem_bridge: RTL

MISAO_MEM_BRIDGE -- requirements
Module: misao_mem_bridge

---
 rtl/misao_mem_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/misao_mem_bridge.sv
// misao_mem_bridge: single-port core-to-external memory bridge with a
// one-byte next-address prefetch buffer and a per-transaction timeout.
//
// Handshakes: the core raises core_rd/core_wr and holds request fields while
// core_wait=1; the access completes in the first cycle with core_wait=0.
// The bridge holds ext_req/ext_we/ext_addr/ext_wdata stable until ext_ack
// (one-cycle strobe) or a timeout abort; ext_ack outside a transaction is
// ignored.
module misao_mem_bridge #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic [7:0]        core_rdata,
  output logic              core_wait,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [7:0]        ext_wdata,
  input  logic [7:0]        ext_rdata,
  input  logic              ext_ack,
  output logic              bus_err,
  output logic              pf_hit,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    PF   = 2'd3
  } state_t;

  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] txn_addr_q;   // address of the running (or next prefetch) transaction
  logic [7:0]        txn_wdata_q;
  logic [ADDR_W-1:0] pf_addr_q;
  logic [7:0]        pf_data_q;
  logic              pf_valid_q;
  logic [7:0]        cnt_q;
  logic              bus_err_q;

  logic busy;
  logic pf_match;
  logic timeout;

  assign busy      = (state_q != IDLE);
  assign pf_match  = pf_valid_q && (core_addr == pf_addr_q);
  assign timeout   = busy && !ext_ack && (cnt_q == CNT_LAST);
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

  // Next state plus all core/external outputs; writes win over reads.
  always_comb begin
    state_d    = state_q;
    core_wait  = 1'b0;
    core_rdata = 8'h00;
    pf_hit     = 1'b0;
    ext_req    = busy;
    ext_we     = (state_q == WR);
    ext_addr   = busy ? txn_addr_q : '0;
    ext_wdata  = (state_q == WR) ? txn_wdata_q : 8'h00;
    case (state_q)
      IDLE: begin
        if (core_wr) begin
          core_wait = 1'b1;
          state_d   = WR;
        end else if (core_rd) begin
          if (pf_match) begin
            core_rdata = pf_data_q;
            pf_hit     = 1'b1;
            state_d    = PF;
          end else begin
            core_wait = 1'b1;
            state_d   = RD;
          end
        end
      end
      RD: begin
        if (ext_ack) begin
          core_rdata = ext_rdata;
          state_d    = PF;
        end else if (timeout) begin
          core_rdata = 8'hFF;
          state_d    = IDLE;
        end else begin
          core_wait = 1'b1;
        end
      end
      WR: begin
        if (ext_ack || timeout) state_d = IDLE;
        else                    core_wait = 1'b1;
      end
      PF: begin
        // A new core request waits for the prefetch, then restarts from IDLE.
        core_wait = core_rd | core_wr;
        if (ext_ack || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter, transaction latches and prefetch buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      txn_addr_q  <= '0;
      txn_wdata_q <= 8'h00;
      pf_addr_q   <= '0;
      pf_data_q   <= 8'h00;
      pf_valid_q  <= 1'b0;
      cnt_q       <= 8'h00;
      bus_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)     cnt_q <= 8'h00;
      else if (busy && !ext_ack)  cnt_q <= cnt_q + 8'd1;
      if (timeout) bus_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (core_wr) begin
            txn_addr_q  <= core_addr;
            txn_wdata_q <= core_wdata;
          end else if (core_rd) begin
            if (pf_match) begin
              // Buffer is refilled by the following prefetch; invalid until then.
              txn_addr_q <= pf_addr_q + ADDR_ONE;
              pf_valid_q <= 1'b0;
            end else begin
              txn_addr_q <= core_addr;
            end
          end
        end
        RD: begin
          if (ext_ack) begin
            txn_addr_q <= txn_addr_q + ADDR_ONE;
            pf_valid_q <= 1'b0;
          end
        end
        WR: begin
          // Drop a stale prefetched copy of the written byte.
          if ((ext_ack || timeout) && (txn_addr_q == pf_addr_q)) pf_valid_q <= 1'b0;
        end
        PF: begin
          if (ext_ack) begin
            pf_data_q  <= ext_rdata;
            pf_addr_q  <= txn_addr_q;
            pf_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
